// File: rtl/img_stream_reader_pkg.sv
// Shared definitions for the Sobel pixel path: default frame size,
// FSM state encoding and small sizing helpers.
package img_stream_reader_pkg;

    // Default frame geometry shared by every Sobel-path block
    localparam int DEF_MAX_ROW = 540;
    localparam int DEF_MAX_COL = 540;
    localparam int DEF_ADDR_W  = 19;

    // Reader FSM encoding
    localparam int ST_W = 3;
    typedef logic [ST_W-1:0] state_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_READ      = 3'd1;
    localparam logic [2:0] ST_DRAIN     = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    // Cycles from the last read issue until its byte leaves DATA_O
    localparam int RD_LAT       = 2;
    localparam int DRAIN_CYCLES = RD_LAT;

    // Counter width for a range of n values; never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/img_stream_reader_raster_counter.sv
// Raster position tracker: column/row counters with wrap plus a linear
// pixel counter. All three return to 0 after the final pixel so none of
// them ever overflows.
module raster_counter
    import img_stream_reader_pkg::*;
#(
    parameter int MAX_ROW = DEF_MAX_ROW,
    parameter int MAX_COL = DEF_MAX_COL,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              adv,
    output logic [ADDR_W-1:0] pix,
    output logic              last
);

    localparam int COL_W = cnt_w(MAX_COL);
    localparam int ROW_W = cnt_w(MAX_ROW);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_last;

    assign col_last = (col == COL_W'(MAX_COL - 1));
    assign last     = col_last && (row == ROW_W'(MAX_ROW - 1));

    // Step through the frame in raster order; wrap everything on the last pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
            pix <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
            pix <= '0;
        end else if (adv) begin
            if (last) begin
                col <= '0;
                row <= '0;
                pix <= '0;
            end else if (col_last) begin
                col <= '0;
                row <= row + ROW_W'(1);
                pix <= pix + ADDR_W'(1);
            end else begin
                col <= col + COL_W'(1);
                pix <= pix + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/img_stream_reader.sv
// Frame reader: streams one image out of the frame RAM in raster order
// into the Sobel core, then waits for the core to finish before
// reporting frame completion.
module img_stream_reader
    import img_stream_reader_pkg::*;
#(
    parameter int MAX_ROW = DEF_MAX_ROW,
    parameter int MAX_COL = DEF_MAX_COL,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START_I,
    input  logic              STALL_I,
    output logic [ADDR_W-1:0] MEM_ADDR_O,
    output logic              MEM_RD_EN_O,
    input  logic [7:0]        MEM_DATA_I,
    output logic [7:0]        DATA_O,
    output logic              DATA_EN_O,
    output logic              CORE_RUN_O,
    input  logic              CORE_DONE_I,
    output logic              FRAME_DONE_O,
    output logic              BUSY_O
);

    state_t            state;
    logic [0:0]        drain_cnt;
    logic              rd_en;
    logic              clr;
    logic              last;
    logic [ADDR_W-1:0] pix;
    // vld_pipe[1]: RAM data valid on MEM_DATA_I; vld_pipe[2]: byte on DATA_O
    logic [RD_LAT:1]   vld_pipe;

    // A read is issued every unstalled READ cycle; a start clears the counters
    assign rd_en = (state == ST_READ) && !STALL_I;
    assign clr   = (state == ST_IDLE) && START_I;

    raster_counter #(
        .MAX_ROW (MAX_ROW),
        .MAX_COL (MAX_COL),
        .ADDR_W  (ADDR_W)
    ) u_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (clr),
        .adv   (rd_en),
        .pix   (pix),
        .last  (last)
    );

    // Frame sequencing; START_I only counts in IDLE, CORE_DONE_I only in WAIT_DONE
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START_I) state <= ST_READ;
                end
                ST_READ: begin
                    if (rd_en && last) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 1'(DRAIN_CYCLES - 1)) state <= ST_WAIT_DONE;
                    else drain_cnt <= drain_cnt + 1'b1;
                end
                ST_WAIT_DONE: begin
                    if (CORE_DONE_I) state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read-data pipeline: capture RAM data the cycle after the strobe, hold otherwise
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_pipe <= '0;
            DATA_O   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LAT-1:1], rd_en};
            if (vld_pipe[1]) DATA_O <= MEM_DATA_I;
        end
    end

    assign DATA_EN_O    = vld_pipe[RD_LAT];
    assign MEM_RD_EN_O  = rd_en;
    assign MEM_ADDR_O   = pix;
    // Core stays running from READ entry through the cycle its done is seen
    assign CORE_RUN_O   = (state == ST_READ) || (state == ST_DRAIN) || (state == ST_WAIT_DONE);
    assign FRAME_DONE_O = (state == ST_DONE);
    assign BUSY_O       = (state != ST_IDLE);

endmodule
